// File: rtl/operand_stack_pkg.sv
// operand_stack_pkg: stack-pointer op encodings and default depth shared by the operand stack.
package operand_stack_pkg;
  localparam logic [1:0] DES_2 = 2'd0;
  localparam logic [1:0] DES_1 = 2'd1;
  localparam logic [1:0] ADV_0 = 2'd2;
  localparam logic [1:0] ADV_1 = 2'd3;
  typedef enum logic [1:0] {
    OP_DES_2 = DES_2,
    OP_DES_1 = DES_1,
    OP_ADV_0 = ADV_0,
    OP_ADV_1 = ADV_1
  } sp_op_t;
  localparam int STACK_DEPTH = 16;
endpackage

// File: rtl/operand_stack_spill_ram.sv
// stack_spill_ram: spill storage below top/second; sync write, async reads (third read port with OPSTACK_DBG_EN).
module stack_spill_ram #(
  parameter int N  = 14,
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] rd_a_i,
  input  logic [AW-1:0] rd_b_i,
  output logic [W-1:0]  rd_a_o,
  output logic [W-1:0]  rd_b_o
`ifdef OPSTACK_DBG_EN
  ,
  input  logic [AW-1:0] rd_c_i,
  output logic [W-1:0]  rd_c_o
`endif
);
  logic [W-1:0] mem [N];
  always_ff @(posedge clk)
    if (we_i) mem[waddr_i] <= wdata_i;
  // Addresses past the array come from wrapped pointers; the top masks those reads anyway.
  assign rd_a_o = (rd_a_i < AW'(N)) ? mem[rd_a_i] : '0;
  assign rd_b_o = (rd_b_i < AW'(N)) ? mem[rd_b_i] : '0;
`ifdef OPSTACK_DBG_EN
  assign rd_c_o = (rd_c_i < AW'(N)) ? mem[rd_c_i] : '0;
`endif
endmodule

// File: rtl/operand_stack.sv
// operand_stack: register top/second plus spill RAM, with legality checks and sticky ovf/unf flags.
// Optional debug read port (dbg_idx/dbg_data) enabled by OPSTACK_DBG_EN.
module operand_stack
  import operand_stack_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int W     = 8,
  localparam int CW   = $clog2(DEPTH+1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          op_valid,
  input  logic [1:0]    sp_op,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  top_st,
  output logic [W-1:0]  snd_st,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          ovf_err,
  output logic          unf_err
`ifdef OPSTACK_DBG_EN
  ,
  input  logic [AW-1:0] dbg_idx,
  output logic [W-1:0]  dbg_data
`endif
);
  logic [W-1:0]  top_q, top_d, snd_q, snd_d, rd_a, rd_b;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, unf_q, unf_d, we;
  logic [AW-1:0] waddr, ra, rb;
  assign waddr = AW'(count_q - CW'(2));
  assign ra    = AW'(count_q - CW'(3));
  assign rb    = AW'(count_q - CW'(4));
  assign empty = count_q == '0;
  assign full  = count_q == CW'(DEPTH);
`ifdef OPSTACK_DBG_EN
  logic [CW-1:0] di;
  logic [W-1:0]  rd_c;
  assign di       = CW'(dbg_idx);
  assign dbg_data = (di >= count_q) ? '0 : (di == '0) ? top_q : (di == CW'(1)) ? snd_q : rd_c;
`endif
  stack_spill_ram #(.N(DEPTH-2), .W(W), .AW(AW)) u_spill (
    .clk     (CLK),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (snd_q),
    .rd_a_i  (ra),
    .rd_b_i  (rb),
    .rd_a_o  (rd_a),
    .rd_b_o  (rd_b)
`ifdef OPSTACK_DBG_EN
    ,
    .rd_c_i  (AW'(count_q - CW'(1) - di)),
    .rd_c_o  (rd_c)
`endif
  );
  // Illegal ops only raise a flag; popped registers load 0 when nothing lies beneath them.
  always_comb begin
    top_d   = top_q;
    snd_d   = snd_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    if (op_valid)
      case (sp_op_t'(sp_op))
        OP_ADV_1:
          if (full) ovf_d = 1'b1;
          else begin
            we      = count_q >= CW'(2);
            snd_d   = top_q;
            top_d   = wr_data;
            count_d = count_q + CW'(1);
          end
        OP_ADV_0:
          if (empty) unf_d = 1'b1;
          else top_d = wr_data;
        OP_DES_1:
          if (count_q < CW'(2)) unf_d = 1'b1;
          else begin
            top_d   = wr_data;
            snd_d   = (count_q >= CW'(3)) ? rd_a : '0;
            count_d = count_q - CW'(1);
          end
        default:
          if (count_q < CW'(2)) unf_d = 1'b1;
          else begin
            top_d   = (count_q >= CW'(3)) ? rd_a : '0;
            snd_d   = (count_q >= CW'(4)) ? rd_b : '0;
            count_d = count_q - CW'(2);
          end
      endcase
  end
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      top_q   <= '0;
      snd_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      snd_q   <= snd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  assign top_st  = top_q;
  assign snd_st  = snd_q;
  assign count   = count_q;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
endmodule

// File: tb/tb_operand_stack.sv
// tb_operand_stack: directed stimulus with hand-computed expectations for operand_stack (DEPTH=16, W=8).
module tb_operand_stack;
  import operand_stack_pkg::*;
  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       op_valid = 1'b0;
  logic [1:0] sp_op = ADV_0;
  logic [7:0] wr_data = '0;
  logic [7:0] top_st, snd_st;
  logic [4:0] count;
  logic       empty, full, ovf_err, unf_err;
  int         n_cmp = 0;
  int         n_bad = 0;
`ifdef OPSTACK_DBG_EN
  logic [3:0] dbg_idx = '0;
  logic [7:0] dbg_data;
`endif
  operand_stack dut (
    .CLK      (CLK),
    .reset    (reset),
    .op_valid (op_valid),
    .sp_op    (sp_op),
    .wr_data  (wr_data),
    .top_st   (top_st),
    .snd_st   (snd_st),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .ovf_err  (ovf_err),
    .unf_err  (unf_err)
`ifdef OPSTACK_DBG_EN
    ,
    .dbg_idx  (dbg_idx),
    .dbg_data (dbg_data)
`endif
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic st(input string tag, input int t, input int s, input int c);
    chk({tag, ".top"}, 32'(top_st), 32'(t));
    chk({tag, ".snd"}, 32'(snd_st), 32'(s));
    chk({tag, ".count"}, 32'(count), 32'(c));
  endtask
  task automatic flags(input string tag, input logic e, input logic f, input logic o, input logic u);
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".full"}, 32'(full), 32'(f));
    chk({tag, ".ovf"}, 32'(ovf_err), 32'(o));
    chk({tag, ".unf"}, 32'(unf_err), 32'(u));
  endtask
  task automatic step(input logic v, input logic [1:0] op, input logic [7:0] d);
    op_valid = v;
    sp_op    = op;
    wr_data  = d;
    @(posedge CLK);
    #1;
    op_valid = 1'b0;
  endtask
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    #3 reset = 1'b0;
  endtask
  initial begin
    #1 reset = 1'b1;
    #1;
    st("rst0", 0, 0, 0);
    flags("rst0", 1, 0, 0, 0);
    @(posedge CLK);
    #1 reset = 1'b0;
    step(1, ADV_1, 8'd5);
    st("push1", 5, 0, 1);
    step(1, ADV_1, 8'd3);
    step(1, ADV_1, 8'd9);
    st("t2push", 9, 3, 3);
    step(1, DES_1, 8'd12);
    st("t2des1", 12, 5, 2);
    step(1, ADV_1, 8'd7);
    #2 reset = 1'b1;
    #1;
    st("t1async", 0, 0, 0);
    flags("t1async", 1, 0, 0, 0);
    #3 reset = 1'b0;
    for (int i = 1; i <= 4; i++) step(1, ADV_1, 8'(i));
    st("t3fill", 4, 3, 4);
    step(1, DES_2, 8'hFF);
    st("t3des2", 2, 1, 2);
    step(1, ADV_0, 8'h80);
    st("t3adv0", 8'h80, 1, 2);
    flags("t3", 0, 0, 0, 0);
    step(1, ADV_1, 8'd2);
    step(1, DES_2, 8'hFF);
    st("des2c3", 1, 0, 1);
    do_reset();
    for (int i = 0; i < 16; i++) step(1, ADV_1, 8'(i));
    st("t4full", 15, 14, 16);
    flags("t4full", 0, 1, 0, 0);
    step(1, ADV_1, 8'hAA);
    st("t4ovf", 15, 14, 16);
    flags("t4ovf", 0, 1, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      step(1, DES_2, 8'h55);
      st($sformatf("t4pop%0d", k), (k < 8) ? 15 - 2 * k : 0, (k < 8) ? 14 - 2 * k : 0, 16 - 2 * k);
    end
    flags("t4end", 1, 0, 1, 0);
    do_reset();
    step(1, ADV_0, 8'd1);
    st("adv0empty", 0, 0, 0);
    flags("adv0empty", 1, 0, 0, 1);
    do_reset();
    step(1, ADV_1, 8'd42);
    step(1, DES_1, 8'd99);
    st("t5des1", 42, 0, 1);
    flags("t5des1", 0, 0, 0, 1);
    step(0, ADV_1, 8'd55);
    st("t5hold", 42, 0, 1);
    step(1, DES_2, 8'd0);
    st("t5des2", 42, 0, 1);
    flags("t5end", 0, 0, 0, 1);
`ifdef OPSTACK_DBG_EN
    do_reset();
    step(1, ADV_1, 8'd7);
    step(1, ADV_1, 8'd8);
    step(1, ADV_1, 8'd9);
    for (int i = 0; i < 4; i++) begin
      dbg_idx = 4'(i);
      #1;
      chk($sformatf("t6dbg%0d", i), 32'(dbg_data), (i == 0) ? 9 : (i == 1) ? 8 : (i == 2) ? 7 : 0);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
